// File: rtl/adder_ripple_pkg.sv
// Shared constants for the instrumented ripple-carry adder wrapper.
// Command and status bit positions on the LA3 bus.
package adder_ripple_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IO_W  = 38;
    localparam int unsigned CMD_W = 7;

    localparam int unsigned CMD_LOAD_A     = 0;
    localparam int unsigned CMD_LOAD_B     = 1;
    localparam int unsigned CMD_LOAD_EXT   = 2;
    localparam int unsigned CMD_LOAD_RING  = 3;
    localparam int unsigned CMD_LOAD_OMASK = 4;
    localparam int unsigned CMD_RUN        = 5;
    localparam int unsigned CMD_CLR        = 6;

    localparam int unsigned STATUS_CHAIN = 0;
    localparam int unsigned STATUS_CARRY = 1;

endpackage

// File: rtl/ripple_adder_core.sv
// Structural ripple-carry adder: one full-adder cell per bit, carry chained
// cell to cell so the critical path is the explicit chain.
module ripple_adder_core
    import adder_ripple_pkg::*;
(
    input  logic [WIDTH-1:0] a_eff,
    input  logic [WIDTH-1:0] b_input,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic cin;
        logic cout;

        if (i == 0) begin : g_lsb
            assign cin = 1'b0;
        end else begin : g_chain
            assign cin = g_bit[i-1].cout;
        end

        assign sum[i] = a_eff[i] ^ b_input[i] ^ cin;
        assign cout   = (a_eff[i] & b_input[i]) | (cin & (a_eff[i] ^ b_input[i]));
    end

    assign carry = g_bit[WIDTH-1].cout;

endmodule

// File: rtl/wrapped_instrumented_adder_ripple.sv
// Caravel project wrapper: LA-driven operand/mask registers feeding a ripple
// adder whose registered sum can loop back into operand A, plus an edge counter.
module wrapped_instrumented_adder_ripple
    import adder_ripple_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             active,
    input  logic [31:0]      la1_data_in,
    output logic [31:0]      la1_data_out,
    input  logic [31:0]      la1_oenb,
    input  logic [31:0]      la2_data_in,
    output logic [31:0]      la2_data_out,
    input  logic [31:0]      la2_oenb,
    input  logic [31:0]      la3_data_in,
    output logic [31:0]      la3_data_out,
    input  logic [31:0]      la3_oenb,
    input  logic [IO_W-1:0]  io_in,
    output logic [IO_W-1:0]  io_out,
    output logic [IO_W-1:0]  io_oeb
);

    logic [WIDTH-1:0] a_input;
    logic [WIDTH-1:0] b_input;
    logic [WIDTH-1:0] a_input_ext_bit_b;
    logic [WIDTH-1:0] a_input_ring_bit_b;
    logic [WIDTH-1:0] s_output_bit_b;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] counter;
    logic             carry_reg;
    logic             chain_out;

    logic [CMD_W-1:0] cmd;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             chain_out_next;

    logic unused_inputs;
    assign unused_inputs = ^{la1_oenb, la2_oenb, io_in,
                             la3_data_in[31:CMD_W], la3_oenb[31:CMD_W]};

    assign cmd = {CMD_W{active}} & la3_data_in[CMD_W-1:0] & ~la3_oenb[CMD_W-1:0];

    // Ring selection wins over the external operand; s_reg breaks the loop.
    assign a_eff = (a_input_ring_bit_b & s_reg)
                 | (~a_input_ring_bit_b & a_input_ext_bit_b & a_input);

    ripple_adder_core u_core (
        .a_eff   (a_eff),
        .b_input (b_input),
        .sum     (sum),
        .carry   (carry)
    );

    assign chain_out_next = |(sum & s_output_bit_b);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            a_input            <= '0;
            b_input            <= '0;
            a_input_ext_bit_b  <= '0;
            a_input_ring_bit_b <= '0;
            s_output_bit_b     <= '0;
            s_reg              <= '0;
            counter            <= '0;
            carry_reg          <= 1'b0;
            chain_out          <= 1'b0;
        end else begin
            if (cmd[CMD_LOAD_A])     a_input            <= la1_data_in;
            if (cmd[CMD_LOAD_B])     b_input            <= la2_data_in;
            if (cmd[CMD_LOAD_EXT])   a_input_ext_bit_b  <= la1_data_in;
            if (cmd[CMD_LOAD_RING])  a_input_ring_bit_b <= la1_data_in;
            if (cmd[CMD_LOAD_OMASK]) s_output_bit_b     <= la2_data_in;

            if (cmd[CMD_RUN]) begin
                s_reg     <= sum;
                carry_reg <= carry;
                chain_out <= chain_out_next;
            end

            if (cmd[CMD_CLR]) begin
                counter <= '0;
            end else if (cmd[CMD_RUN] && !chain_out && chain_out_next) begin
                counter <= counter + 32'd1;
            end
        end
    end

    always_comb begin
        la1_data_out = '0;
        la2_data_out = '0;
        la3_data_out = '0;
        io_out       = '0;
        io_oeb       = '1;
        if (active) begin
            la1_data_out               = s_reg;
            la2_data_out               = counter;
            la3_data_out[STATUS_CHAIN] = chain_out;
            la3_data_out[STATUS_CARRY] = carry_reg;
            io_out[0]                  = chain_out;
            io_out[1]                  = carry_reg;
            io_oeb                     = '0;
        end
    end

endmodule

// File: tb/tb_wrapped_instrumented_adder_ripple.sv
// Scoreboard bench: stimulus pushes model-predicted outputs per cycle; a
// monitor pops and compares one entry after every rising edge.
module tb_wrapped_instrumented_adder_ripple;

    localparam logic [6:0] C_A    = 7'h01;
    localparam logic [6:0] C_B    = 7'h02;
    localparam logic [6:0] C_EXT  = 7'h04;
    localparam logic [6:0] C_RING = 7'h08;
    localparam logic [6:0] C_OM   = 7'h10;
    localparam logic [6:0] C_RUN  = 7'h20;
    localparam logic [6:0] C_CLR  = 7'h40;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        active = 1'b0;
    logic [31:0] la1_data_in = '0, la1_data_out, la1_oenb = '0;
    logic [31:0] la2_data_in = '0, la2_data_out, la2_oenb = '0;
    logic [31:0] la3_data_in = '0, la3_data_out, la3_oenb = '1;
    logic [37:0] io_in = '0, io_out, io_oeb;

    wrapped_instrumented_adder_ripple dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .active(active),
        .la1_data_in(la1_data_in), .la1_data_out(la1_data_out), .la1_oenb(la1_oenb),
        .la2_data_in(la2_data_in), .la2_data_out(la2_data_out), .la2_oenb(la2_oenb),
        .la3_data_in(la3_data_in), .la3_data_out(la3_data_out), .la3_oenb(la3_oenb),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        int          cyc;
        logic [31:0] l1, l2, l3;
        logic [37:0] io, oeb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference state
    logic [31:0] m_a, m_b, m_ext, m_ring, m_om, m_s, m_cnt;
    logic        m_carry, m_chain;

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, c, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue the prediction.
    task automatic step(input logic rst, input logic act, input logic [31:0] l1,
                        input logic [31:0] l2, input logic [6:0] cmdb, input logic [6:0] oenb_lo);
        logic [31:0] r1, r2, aeff;
        logic [32:0] full;
        logic [6:0]  c;
        logic        nchain;
        exp_t        e;
        @(negedge wb_clk_i);
        r1 = $urandom();
        r2 = $urandom();
        wb_rst_i    = rst;
        active      = act;
        la1_data_in = l1;
        la2_data_in = l2;
        la3_data_in = {r1[31:7], cmdb};
        la3_oenb    = {r2[31:7], oenb_lo};
        la1_oenb    = $urandom();
        la2_oenb    = $urandom();
        io_in       = {6'($urandom()), 32'($urandom())};
        cyc++;

        c = act ? (cmdb & ~oenb_lo) : 7'h0;
        if (rst) begin
            {m_a, m_b, m_ext, m_ring, m_om, m_s, m_cnt} = '0;
            m_carry = 1'b0;
            m_chain = 1'b0;
        end else begin
            for (int i = 0; i < 32; i++)
                aeff[i] = m_ring[i] ? m_s[i] : (m_ext[i] ? m_a[i] : 1'b0);
            full   = 33'(aeff) + 33'(m_b);
            nchain = (full[31:0] & m_om) != 0;
            if (c[6])                          m_cnt = 0;
            else if (c[5] && nchain && !m_chain) m_cnt = m_cnt + 1;
            if (c[5]) begin
                m_s     = full[31:0];
                m_carry = full[32];
                m_chain = nchain;
            end
            if (c[0]) m_a    = l1;
            if (c[1]) m_b    = l2;
            if (c[2]) m_ext  = l1;
            if (c[3]) m_ring = l1;
            if (c[4]) m_om   = l2;
        end

        e.cyc = cyc;
        if (act) begin
            e.l1  = m_s;
            e.l2  = m_cnt;
            e.l3  = {30'b0, m_carry, m_chain};
            e.io  = {36'b0, m_carry, m_chain};
            e.oeb = '0;
        end else begin
            e.l1 = '0; e.l2 = '0; e.l3 = '0; e.io = '0; e.oeb = '1;
        end
        q.push_back(e);
    endtask

    task automatic go(input logic [31:0] l1, input logic [31:0] l2, input logic [6:0] cmdb);
        step(1'b0, 1'b1, l1, l2, cmdb, 7'h0);
    endtask

    task automatic settle();
        @(posedge wb_clk_i);
        #2;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("la1_data_out", e.cyc, 64'(la1_data_out), 64'(e.l1));
                chk("la2_data_out", e.cyc, 64'(la2_data_out), 64'(e.l2));
                chk("la3_data_out", e.cyc, 64'(la3_data_out), 64'(e.l3));
                chk("io_out",       e.cyc, 64'(io_out),       64'(e.io));
                chk("io_oeb",       e.cyc, 64'(io_oeb),       64'(e.oeb));
            end
        end
    end

    initial begin
        {m_a, m_b, m_ext, m_ring, m_om, m_s, m_cnt} = '0;
        m_carry = 1'b0;
        m_chain = 1'b0;

        step(1'b1, 1'b1, '0, '0, C_RUN, 7'h0);
        step(1'b1, 1'b1, '0, '0, '0, 7'h0);
        settle();
        chk("reset_la1", cyc, 64'(la1_data_out), 64'h0);
        chk("reset_la3", cyc, 64'(la3_data_out), 64'h0);

        // Basic add 5 + 7
        go(32'hFFFF_FFFF, '0, C_EXT);
        go(32'h0, '0, C_RING);
        go(32'd5, 32'd7, C_A | C_B);
        go('0, '0, C_RUN);
        settle();
        chk("basic_sum", cyc, 64'(la1_data_out), 64'd12);
        chk("basic_carry", cyc, 64'(la3_data_out[1]), 64'd0);

        // Carry out
        go(32'hFFFF_FFFF, 32'd1, C_A | C_B);
        go('0, '0, C_RUN);
        settle();
        chk("carry_sum", cyc, 64'(la1_data_out), 64'h0);
        chk("carry_la3", cyc, 64'(la3_data_out[1]), 64'd1);
        chk("carry_io", cyc, 64'(io_out[1]), 64'd1);

        // Ring accumulate with chain monitor on bit 0
        go(32'hFFFF_FFFF, 32'd1, C_RING | C_B | C_CLR);
        go('0, 32'd1, C_OM);
        for (int i = 0; i < 10; i++) go('0, '0, C_RUN);
        settle();
        chk("ring_sum", cyc, 64'(la1_data_out), 64'd10);
        chk("ring_count", cyc, 64'(la2_data_out), 64'd5);
        go('0, '0, C_RUN | C_CLR);
        settle();
        chk("clr_priority", cyc, 64'(la2_data_out), 64'd0);

        // Ext mask
        go(32'h0, '0, C_RING);
        go(32'h0000_FFFF, 32'h0, C_EXT | C_B);
        go(32'h1234_5678, '0, C_A);
        go('0, '0, C_RUN);
        settle();
        chk("mask_sum", cyc, 64'(la1_data_out), 64'h5678);

        // oenb blocks load_a
        step(1'b0, 1'b1, 32'hDEAD_BEEF, '0, C_A, 7'h01);
        go('0, '0, C_RUN);
        settle();
        chk("oenb_block", cyc, 64'(la1_data_out), 64'h5678);

        // Inactive: outputs gated, commands ignored
        step(1'b0, 1'b0, 32'h0, '0, C_A | C_RUN, 7'h0);
        settle();
        chk("inactive_la1", cyc, 64'(la1_data_out), 64'h0);
        chk("inactive_oeb", cyc, 64'(io_oeb), 64'h3F_FFFF_FFFF);
        go('0, '0, '0);
        settle();
        chk("reactive_la1", cyc, 64'(la1_data_out), 64'h5678);
        go('0, '0, C_RUN);
        settle();
        chk("ignored_load", cyc, 64'(la1_data_out), 64'h5678);

        // Reset mid-run
        go(32'hFFFF_FFFF, 32'd3, C_RING | C_B | C_OM);
        for (int i = 0; i < 3; i++) go('0, '0, C_RUN);
        step(1'b1, 1'b1, '0, '0, C_RUN, 7'h0);
        settle();
        chk("rst_la1", cyc, 64'(la1_data_out), 64'h0);
        chk("rst_la2", cyc, 64'(la2_data_out), 64'h0);
        chk("rst_la3", cyc, 64'(la3_data_out), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            logic [6:0]  cm, oe;
            r  = $urandom();
            cm = 7'($urandom());
            if (r[3:0] < 4'd10) cm[5] = 1'b1;
            if (r[7:4] != 4'd0) cm[6] = 1'b0;
            oe = (r[11:8] == 4'd0) ? 7'($urandom()) : 7'h0;
            step((r[17:12] == 6'd0), (r[21:18] != 4'd0),
                 (r[22] ? 32'($urandom()) : 32'($urandom_range(0, 15))),
                 (r[23] ? 32'($urandom()) : 32'($urandom_range(0, 3))),
                 cm, oe);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge wb_clk_i);
        #2;
        if (q.size() != 0) chk("drain", cyc, 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
